// File: rtl/srnand_bank.sv
// Bank of CH independent active-low SR latches on one clock, with a forbidden-input policy,
// an optional transparent output path, sticky forbidden flags, a shared saturating event counter and edge pulses.
module srnand_bank #(
  parameter int            CH          = 8,
  parameter logic [CH-1:0] INIT        = {CH{1'b1}},
  parameter int            PRIO        = 0,
  parameter int            TRANSPARENT = 1,
  parameter int            CNTW        = 8
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_CEN_n,
  input  logic [CH-1:0]   i_S_n,
  input  logic [CH-1:0]   i_R_n,
  input  logic            i_ILL_CLR,
  output logic [CH-1:0]   o_Q,
  output logic [CH-1:0]   o_Q_n,
  output logic [CH-1:0]   o_SET_P,
  output logic [CH-1:0]   o_RST_P,
  output logic [CH-1:0]   o_ILL,
  output logic [CNTW-1:0] o_ILL_CNT
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  if (PRIO < 0 || PRIO > 2) begin : g_prio_err
    $error("srnand_bank: PRIO must be 0 (hold), 1 (set wins) or 2 (reset wins)");
  end
  if (CH < 1 || CH > 32) begin : g_ch_err
    $error("srnand_bank: CH must be in 1..32");
  end

  // Per-channel latch evaluation; the 00 case follows the PRIO policy.
  function automatic logic [CH-1:0] latch_eval(input logic [CH-1:0] s_n,
                                               input logic [CH-1:0] r_n,
                                               input logic [CH-1:0] q);
    logic [CH-1:0] res;
    res = q;
    for (int k = 0; k < CH; k++) begin
      case ({s_n[k], r_n[k]})
        2'b01:   res[k] = 1'b1;
        2'b10:   res[k] = 1'b0;
        2'b11:   res[k] = q[k];
        default: res[k] = (PRIO == 1) ? 1'b1 : ((PRIO == 2) ? 1'b0 : q[k]);
      endcase
    end
    return res;
  endfunction

  logic [CH-1:0]   q_q, q_d;
  logic [CH-1:0]   set_p_q, set_p_d;
  logic [CH-1:0]   rst_p_q, rst_p_d;
  logic [CH-1:0]   ill_q, ill_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CH-1:0]   eval_s;
  logic [CH-1:0]   forb_s;

  assign eval_s = latch_eval(i_S_n, i_R_n, q_q);
  assign forb_s = ~i_S_n & ~i_R_n;

  // Next-state: latch/pulses/counter gated by the enable; the flag clear bypasses the enable.
  always_comb begin
    q_d     = q_q;
    set_p_d = '0;
    rst_p_d = '0;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (!i_CEN_n) begin
      q_d     = eval_s;
      set_p_d = eval_s & ~q_q;
      rst_p_d = ~eval_s & q_q;
      ill_d   = ill_q | forb_s;
      if ((|forb_s) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      q_d = q_q;
    end
    if (i_ILL_CLR) begin
      ill_d = '0;
      cnt_d = '0;
    end else begin
      ill_d = ill_d;
    end
  end

  // State registers with synchronous reset taking priority over enable and clear.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      q_q     <= INIT;
      set_p_q <= '0;
      rst_p_q <= '0;
      ill_q   <= '0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      set_p_q <= set_p_d;
      rst_p_q <= rst_p_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transparent mode exposes the would-be next value, masked to INIT while in reset.
  if (TRANSPARENT != 0) begin : g_transp
    assign o_Q = i_RST ? INIT : eval_s;
  end else begin : g_stored
    assign o_Q = q_q;
  end

  assign o_Q_n     = ~o_Q;
  assign o_SET_P   = set_p_q;
  assign o_RST_P   = rst_p_q;
  assign o_ILL     = ill_q;
  assign o_ILL_CNT = cnt_q;

endmodule

// File: tb/tb_srnand_bank.sv
// Directed bench for srnand_bank: five parameter variants share one stimulus bus.
module tb_srnand_bank;

  logic       clk = 1'b0;
  logic       rst, cen_n, ill_clr;
  logic [3:0] s_n, r_n;

  logic [3:0] qA, qnA, spA, rpA, illA; logic [7:0] cntA;
  logic [3:0] qB, qnB, spB, rpB, illB; logic [7:0] cntB;
  logic [3:0] qC, qnC, spC, rpC, illC; logic [7:0] cntC;
  logic [3:0] qD, qnD, spD, rpD, illD; logic [1:0] cntD;
  logic [3:0] qE, qnE, spE, rpE, illE; logic [7:0] cntE;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srnand_bank #(.CH(4), .INIT(4'b1111), .PRIO(0), .TRANSPARENT(1), .CNTW(8)) dA (
    .i_CLK(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_S_n(s_n), .i_R_n(r_n), .i_ILL_CLR(ill_clr),
    .o_Q(qA), .o_Q_n(qnA), .o_SET_P(spA), .o_RST_P(rpA), .o_ILL(illA), .o_ILL_CNT(cntA));
  srnand_bank #(.CH(4), .INIT(4'b1111), .PRIO(1), .TRANSPARENT(1), .CNTW(8)) dB (
    .i_CLK(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_S_n(s_n), .i_R_n(r_n), .i_ILL_CLR(ill_clr),
    .o_Q(qB), .o_Q_n(qnB), .o_SET_P(spB), .o_RST_P(rpB), .o_ILL(illB), .o_ILL_CNT(cntB));
  srnand_bank #(.CH(4), .INIT(4'b1111), .PRIO(2), .TRANSPARENT(1), .CNTW(8)) dC (
    .i_CLK(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_S_n(s_n), .i_R_n(r_n), .i_ILL_CLR(ill_clr),
    .o_Q(qC), .o_Q_n(qnC), .o_SET_P(spC), .o_RST_P(rpC), .o_ILL(illC), .o_ILL_CNT(cntC));
  srnand_bank #(.CH(4), .INIT(4'b1111), .PRIO(0), .TRANSPARENT(1), .CNTW(2)) dD (
    .i_CLK(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_S_n(s_n), .i_R_n(r_n), .i_ILL_CLR(ill_clr),
    .o_Q(qD), .o_Q_n(qnD), .o_SET_P(spD), .o_RST_P(rpD), .o_ILL(illD), .o_ILL_CNT(cntD));
  srnand_bank #(.CH(4), .INIT(4'b0000), .PRIO(0), .TRANSPARENT(0), .CNTW(8)) dE (
    .i_CLK(clk), .i_RST(rst), .i_CEN_n(cen_n), .i_S_n(s_n), .i_R_n(r_n), .i_ILL_CLR(ill_clr),
    .o_Q(qE), .o_Q_n(qnE), .o_SET_P(spE), .o_RST_P(rpE), .o_ILL(illE), .o_ILL_CNT(cntE));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cen_n = 1'b0; ill_clr = 1'b0; s_n = 4'b1111; r_n = 4'b1111;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cen_n = 1'b0; ill_clr = 1'b0; s_n = 4'b1111; r_n = 4'b1110;
    step(); step();
    checks++; if (qA !== 4'b1111) begin errors++; $display("FAIL reset_qA: got %b expected %b", qA, 4'b1111); end
    checks++; if (qnA !== 4'b0000) begin errors++; $display("FAIL reset_qnA: got %b expected %b", qnA, 4'b0000); end
    checks++; if ({spA, rpA, illA} !== 12'h000) begin errors++; $display("FAIL reset_flagsA: got %h expected %h", {spA, rpA, illA}, 12'h000); end
    checks++; if (cntA !== 8'd0) begin errors++; $display("FAIL reset_cntA: got %0d expected %0d", cntA, 8'd0); end
    checks++; if (qE !== 4'b0000) begin errors++; $display("FAIL reset_qE: got %b expected %b", qE, 4'b0000); end
    rst = 1'b0; r_n = 4'b1111;
    step();
  endtask

  task automatic test_transparent_hold();
    cen_n = 1'b1; r_n = 4'b1110;
    #1;
    checks++; if (qA !== 4'b1110) begin errors++; $display("FAIL transp_q: got %b expected %b", qA, 4'b1110); end
    checks++; if (qnA !== 4'b0001) begin errors++; $display("FAIL transp_qn: got %b expected %b", qnA, 4'b0001); end
    step();
    r_n = 4'b1111;
    #1;
    checks++; if (qA !== 4'b1111) begin errors++; $display("FAIL transp_release: got %b expected %b", qA, 4'b1111); end
    checks++; if (rpA !== 4'b0000) begin errors++; $display("FAIL transp_no_rstp: got %b expected %b", rpA, 4'b0000); end
    step();
    checks++; if ({qA, rpA} !== 8'hF0) begin errors++; $display("FAIL transp_stored: got %h expected %h", {qA, rpA}, 8'hF0); end
  endtask

  task automatic test_enabled_reset();
    cen_n = 1'b0; r_n = 4'b1011;
    #1;
    checks++; if (qA !== 4'b1011) begin errors++; $display("FAIL en_reset_q: got %b expected %b", qA, 4'b1011); end
    step();
    r_n = 4'b1111;
    #1;
    checks++; if (rpA !== 4'b0100) begin errors++; $display("FAIL en_reset_rstp: got %b expected %b", rpA, 4'b0100); end
    checks++; if ({spA, qA} !== 8'h0B) begin errors++; $display("FAIL en_reset_hold: got %h expected %h", {spA, qA}, 8'h0B); end
    step();
    checks++; if ({rpA, qA} !== 8'h0B) begin errors++; $display("FAIL en_reset_pulse_end: got %h expected %h", {rpA, qA}, 8'h0B); end
  endtask

  task automatic test_prio();
    do_reset();
    r_n = 4'b1101;
    step();
    r_n = 4'b1111; s_n = 4'b1101; r_n = 4'b1101;
    #1;
    checks++; if ({qA[1], qB[1], qC[1]} !== 3'b010) begin errors++; $display("FAIL prio_transp: got %b expected %b", {qA[1], qB[1], qC[1]}, 3'b010); end
    step();
    s_n = 4'b1111; r_n = 4'b1111;
    #1;
    checks++; if ({qA, qB, qC} !== 12'hDFD) begin errors++; $display("FAIL prio_stored: got %h expected %h", {qA, qB, qC}, 12'hDFD); end
    checks++; if ({illA, illB, illC} !== 12'h222) begin errors++; $display("FAIL prio_ill: got %h expected %h", {illA, illB, illC}, 12'h222); end
    checks++; if ({cntA, cntB, cntC} !== 24'h010101) begin errors++; $display("FAIL prio_cnt: got %h expected %h", {cntA, cntB, cntC}, 24'h010101); end
    checks++; if ({spA, spB, spC} !== 12'h020) begin errors++; $display("FAIL prio_setp: got %h expected %h", {spA, spB, spC}, 12'h020); end
  endtask

  task automatic test_counter_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    s_n = 4'b1100; r_n = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (cntD !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, cntD, exp_cnt[i]); end
    end
    checks++; if ({cntA, illD} !== 12'h053) begin errors++; $display("FAIL sat_wide_cnt: got %h expected %h", {cntA, illD}, 12'h053); end
    ill_clr = 1'b1;
    step();
    checks++; if ({illD, cntD} !== 6'b000000) begin errors++; $display("FAIL clr_wins: got %b expected %b", {illD, cntD}, 6'b000000); end
    ill_clr = 1'b0; cen_n = 1'b1;
    step();
    checks++; if ({illA, cntA} !== 12'h000) begin errors++; $display("FAIL cen_gate_ill: got %h expected %h", {illA, cntA}, 12'h000); end
    cen_n = 1'b0; s_n = 4'b1111; r_n = 4'b1111;
  endtask

  task automatic test_nontransparent();
    do_reset();
    s_n = 4'b0111;
    #1;
    checks++; if (qE !== 4'b0000) begin errors++; $display("FAIL ntr_before: got %b expected %b", qE, 4'b0000); end
    step();
    s_n = 4'b1111;
    #1;
    checks++; if ({qE, spE} !== 8'h88) begin errors++; $display("FAIL ntr_after: got %h expected %h", {qE, spE}, 8'h88); end
    step();
    checks++; if ({qE, spE, rpE} !== 12'h800) begin errors++; $display("FAIL ntr_pulse_end: got %h expected %h", {qE, spE, rpE}, 12'h800); end
  endtask

  task automatic test_reset_midop();
    rst = 1'b1; cen_n = 1'b0; s_n = 4'b1110; r_n = 4'b1111;
    #1;
    checks++; if (qA !== 4'b1111) begin errors++; $display("FAIL midop_mask: got %b expected %b", qA, 4'b1111); end
    step();
    checks++; if ({qE, spE} !== 8'h00) begin errors++; $display("FAIL midop_rst1: got %h expected %h", {qE, spE}, 8'h00); end
    step();
    checks++; if ({qE, spE} !== 8'h00) begin errors++; $display("FAIL midop_rst2: got %h expected %h", {qE, spE}, 8'h00); end
    rst = 1'b0;
    #1;
    checks++; if (qE !== 4'b0000) begin errors++; $display("FAIL midop_release: got %b expected %b", qE, 4'b0000); end
    step();
    checks++; if ({qE, spE} !== 8'h11) begin errors++; $display("FAIL midop_first_edge: got %h expected %h", {qE, spE}, 8'h11); end
    s_n = 4'b1111;
  endtask

  initial begin
    rst = 1'b1; cen_n = 1'b1; ill_clr = 1'b0; s_n = 4'b1111; r_n = 4'b1111;
    test_reset();
    test_transparent_hold();
    test_enabled_reset();
    test_prio();
    test_counter_sat();
    test_nontransparent();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srnand_bank.md
Name: srnand_bank

Overview:
- Parametrised, multi-channel successor to the single NAND-style SR latch primitive.
- Each channel emulates an active-low SR latch on a single clock, gated by a clock enable.
- Each channel has a configurable forbidden-input policy, an optional transparent output path, a sticky forbidden-input flag and registered set/reset edge pulses.
- Used wherever the Konami 005297 recreation needs groups of cross-coupled NAND latches, e.g. control-flag banks in the bubble sequencer.

Parameters:
- CH, 8: number of independent latch channels (1..32).
- INIT, {CH{1'b1}}: per-channel stored value after reset.
- PRIO, 0: response to S_n=R_n=0. 0 = hold, 1 = set wins, 2 = reset wins. PRIO=3 is illegal and must trip an elaboration error.
- TRANSPARENT, 1: 1 = o_Q reflects a pending set/reset combinationally in the same cycle; 0 = o_Q is the stored value only.
- CNTW, 8: width of the forbidden-input event counter.

Ports:
- i_CLK  in  1  sole clock; all state updates on the rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_CEN_n  in  1  active-low clock enable for latch state, edge pulses and counter.
- i_S_n  in  CH  per-channel active-low set.
- i_R_n  in  CH  per-channel active-low reset.
- i_ILL_CLR  in  1  synchronous clear of o_ILL and o_ILL_CNT; does not depend on i_CEN_n.
- o_Q  out  CH  latch outputs.
- o_Q_n  out  CH  bitwise complement of o_Q.
- o_SET_P  out  CH  one-cycle pulse: the channel's stored bit went 0->1.
- o_RST_P  out  CH  one-cycle pulse: the channel's stored bit went 1->0.
- o_ILL  out  CH  sticky flag: the channel saw S_n=R_n=0 on an enabled cycle.
- o_ILL_CNT  out  CNTW  saturating count of enabled cycles in which at least one channel had S_n=R_n=0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. i_RST has priority over i_CEN_n and i_ILL_CLR.
- Reset values:
  - stored bits = INIT;
  - o_Q = INIT and o_Q_n = ~INIT; the transparent path is masked while i_RST=1;
  - o_SET_P = 0, o_RST_P = 0, o_ILL = 0, o_ILL_CNT = 0.
- Next stored bit per channel, on enabled cycles (i_CEN_n=0):
  - {S_n,R_n} = 01: stored bit <= 1.
  - {S_n,R_n} = 10: stored bit <= 0.
  - {S_n,R_n} = 11: hold.
  - {S_n,R_n} = 00: PRIO 0 holds, PRIO 1 sets, PRIO 2 resets.
- With i_CEN_n=1, stored bits, edge pulses (forced to 0) and the counter do not change.
- TRANSPARENT=1 output:
  - o_Q = the value the stored bit would take if the cycle were enabled, computed from the current S_n/R_n and stored bit.
  - This applies regardless of i_CEN_n, so set/reset take effect at the output with zero latency.
  - The stored bit follows one edge later, and only if enabled.
- TRANSPARENT=0 output: o_Q = stored bit, so latency is 1 enabled edge.
- Edge pulses:
  - o_SET_P and o_RST_P are registered, asserted for exactly the one cycle after the stored bit changed.
  - They are never asserted together on one channel.
- Forbidden input (o_ILL, o_ILL_CNT):
  - o_ILL[k] is set on any enabled edge with S_n[k]=R_n[k]=0, for every PRIO value.
  - It stays set until i_ILL_CLR or i_RST.
  - If i_ILL_CLR and a new forbidden input occur on the same edge, the clear wins and the flag reads 0.
  - o_ILL_CNT increments by 1 per qualifying edge, however many channels are involved, and saturates at 2^CNTW-1 with no wrap.
- Channels are fully independent; no cross-channel interaction except o_ILL_CNT.
- Reset mid-operation: asserting i_RST on a cycle with a pending set/reset discards that set/reset. The first post-reset edge evaluates inputs normally.

Test Plan:
- CH=4, INIT=4'b1111, TRANSPARENT=1: release reset, drive R_n=4'b1110 with CEN_n=1 -> o_Q[0]=0 immediately, stored bit stays 1. Release R_n -> o_Q[0]=1 again, no o_RST_P.
- Same config, CEN_n=0, R_n[2]=0 for one cycle -> o_Q[2]=0 that cycle; o_RST_P[2]=1 on the following cycle only; o_Q[2] stays 0 after R_n returns to 1.
- PRIO=0/1/2 sweep, channel 1 at 0, drive S_n[1]=R_n[1]=0 enabled -> o_Q[1] = 0/1/0 respectively. o_ILL[1]=1 and o_ILL_CNT=1 in all three.
- CNTW=2: hold two channels at 00 for 5 enabled cycles -> o_ILL_CNT reads 1,2,3,3,3. Assert i_ILL_CLR together with a further 00 -> o_ILL=0 and o_ILL_CNT=0.
- TRANSPARENT=0: S_n[3]=0 enabled on edge N -> o_Q[3] rises after edge N, not before; o_SET_P[3]=1 for exactly one cycle.
- i_RST asserted in the same cycle as S_n[0]=0 with INIT[0]=0 -> o_Q[0]=0 throughout reset, stored bit 0, no o_SET_P. After reset release with S_n[0] still 0 -> o_Q[0]=1 next edge.
